mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Parametrised memory-bus controller between the CPU's `mem_cmd`/`mem_addr` port and the data RAM plus memory-mapped I/O (switch input, LED output). It decodes each request, sequences a RAM access of configurable read latency, and returns a registered `read_data` with a one-cycle `mem_ready` pulse. This is the top-level glue block: it replaces ad-hoc tri-state and decode logic with a single handshaked, fully registered bus.

## Interface
- `ADDR_W`, 9: CPU address width.
- `DATA_W`, 16: data width.
- `RAM_DEPTH`, 256: RAM words, mapped at addresses `0 .. RAM_DEPTH-1`.
- `RAM_LAT`, 1: RAM read latency in cycles, 1..7.
- `LED_ADDR`, 9'h100: LED register address.
- `SW_ADDR`, 9'h140: switch register address.
- `IO_W`, 8: LED and switch width; must be ≤ DATA_W.
- `clk  in  1`: rising-edge clock.
- `reset  in  1`: synchronous, active-high.
- `mem_cmd  in  2`: 00 NONE, 01 READ, 10 WRITE, 11 reserved.
- `mem_addr  in  ADDR_W`: request address, held stable until `mem_ready`.
- `write_data  in  DATA_W`: write data, held stable with `mem_addr`.
- `read_data  out  DATA_W`: registered read result, valid while `mem_ready` is high.
- `mem_ready  out  1`: one-cycle completion pulse.
- `ram_addr  out  $clog2(RAM_DEPTH)`: registered RAM address.
- `ram_din  out  DATA_W`: registered RAM write data.
- `ram_write  out  1`: one-cycle RAM write strobe.
- `ram_dout  in  DATA_W`: RAM read data, valid `RAM_LAT` cycles after `ram_addr` changes.
- `sw_in  in  IO_W`: asynchronous switch inputs.
- `led_out  out  IO_W`: LED register.
- `bus_err  out  1`: sticky error flag; present only with `MEM_BUS_ERR_EN` defined.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - RAM_WAIT: counts down the RAM read latency.
  - RESP: pulses `mem_ready`.
- IDLE, `mem_cmd` NONE or 11: remain in IDLE; no side effects.
- IDLE, `mem_cmd` READ or WRITE (acceptance edge): capture address and data, then decode.
- Decode:
  - RAM region: `mem_addr < RAM_DEPTH`.
  - LED: `mem_addr == LED_ADDR`.
  - SW: `mem_addr == SW_ADDR`.
  - Anything else is unmapped.
- RAM READ: load `ram_addr`, load latency counter with `RAM_LAT-1`, go to RAM_WAIT. When the counter reaches 0, register `ram_dout` into `read_data` and go to RESP.
- RAM WRITE: register `ram_addr`/`ram_din`, set `ram_write` for exactly one cycle (the RESP cycle), go to RESP.
- LED WRITE: `led_out <= write_data[IO_W-1:0]`, go to RESP.
- LED READ: return `led_out`, zero-extended.
- SW READ: return the 2-flop-synchronised `sw_in`, zero-extended.
- SW WRITE: ignored, but still completes.
- Unmapped READ: returns 0. Unmapped WRITE: no effect. Both complete with `mem_ready`.
- RESP: `mem_ready`=1 for one cycle, then IDLE. A command present in the cycle after RESP is a new request; the CPU must change or drop `mem_cmd` within that cycle.
- `read_data` holds its last value until the next read completes.

## Timing
- Reset values: `read_data`=0, `mem_ready`=0, `ram_write`=0, `ram_addr`=0, `ram_din`=0, `led_out`=0, `bus_err`=0, synchroniser=0, FSM=IDLE.
- Acceptance at edge k:
  - I/O, unmapped, or RAM write: `mem_ready` high in cycle k+1.
  - RAM read: `mem_ready` high in cycle k+1+RAM_LAT.
- Throughput:
  - Non-RAM-read request: one every 2 cycles.
  - RAM read: one every RAM_LAT+2 cycles.
- `ram_write` is coincident with `mem_ready` for RAM writes and is never asserted otherwise.
- `led_out` changes in cycle k+1.
- `sw_in` reads reflect the pin value from 2 cycles earlier or older.
- Reset asserted mid-access:
  - aborts the access and returns to IDLE next cycle;
  - no pending `ram_write` or `mem_ready` is issued;
  - `led_out` clears.
- `mem_addr` values with bits set above the RAM range are never aliased into RAM.

## Configuration
- `MEM_BUS_ERR_EN` defined:
  - Port `bus_err` exists.
  - These set `bus_err` at the acceptance edge: an unmapped access; a write to SW; an accepted `mem_cmd` 11, which is treated as a request that completes with `mem_ready` and no side effects.
  - `bus_err` clears only on reset.
- Not defined: no `bus_err` port; these cases complete silently, and `mem_cmd` 11 is ignored like NONE.

## Structure
- Shared package `mem_bus_pkg`:
  - `mem_cmd` encodings MNONE/MREAD/MWRITE/MRSVD;
  - FSM state enum;
  - default `LED_ADDR`/`SW_ADDR` constants.
- One sub-module, `sync2`: parametrised 2-flop synchroniser for `sw_in`.
- All other logic is in `mem_bus_ctrl`; no internal tri-states.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `mem_ready` never high.
- WRITE 0x0005 to addr 0x003, then READ 0x003 (RAM_LAT=1) → `ram_write` pulses once with `ram_addr`=3, `ram_din`=5; read gives `mem_ready` at k+2 with `read_data`=0x0005.
- RAM_LAT=3: READ addr 0x010 → `mem_ready` exactly 4 cycles after acceptance with the RAM value.
- WRITE 0x00A5 to 0x100, then READ 0x100 → `led_out`=0xA5 at k+1; read returns 0x00A5.
- `sw_in`=0x3C, then READ 0x140 → `read_data`=0x003C; when `sw_in` changes 1 cycle before acceptance, the old value is returned.
- Unmapped READ 0x1FF under `MEM_BUS_ERR_EN` → `read_data`=0, `bus_err`=1 and sticky.
- Reset asserted during RAM_WAIT → no `mem_ready`, FSM back in IDLE.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus controller: CPU command encodings,
// controller FSM states and default memory-map addresses for the I/O registers.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MRSVD  = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StRamWait,
        StResp
    } bus_state_e;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears both stages
//   d     - asynchronous input bus
//   q     - synchronised output, two cycles behind d
module sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller between the CPU request port and the data RAM plus
// memory-mapped LED/switch registers. Every request completes with a one-cycle
// mem_ready pulse; RAM reads wait RAM_LAT cycles for ram_dout.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   mem_cmd/mem_addr       - CPU request (held until mem_ready)
//   write_data/read_data   - CPU write data / registered read result
//   mem_ready              - completion pulse
//   ram_addr/ram_din/ram_write/ram_dout - RAM port
//   sw_in/led_out          - switch inputs (async), LED register
//   bus_err                - sticky error flag, only when MEM_BUS_ERR_EN is defined
// Optional feature macro: MEM_BUS_ERR_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 9,
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        RAM_DEPTH = 256,
    parameter int unsigned        RAM_LAT   = 1,
    parameter logic [ADDR_W-1:0]  LED_ADDR  = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0]  SW_ADDR   = SW_ADDR_DEF,
    parameter int unsigned        IO_W      = 8,
    localparam int unsigned       RAM_AW    = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [IO_W-1:0]   sw_in,
    output logic [IO_W-1:0]   led_out
`ifdef MEM_BUS_ERR_EN
    ,
    output logic              bus_err
`endif
);

    bus_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              mem_ready_q, mem_ready_d;
    logic              ram_write_q, ram_write_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [IO_W-1:0]   led_q, led_d;
    logic [IO_W-1:0]   sw_sync;
    logic              err_hit;

    mem_cmd_e cmd;
    logic     accept, is_ram, is_led, is_sw;

    sync2 #(
        .WIDTH(IO_W)
    ) u_sw_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sw_in),
        .q    (sw_sync)
    );

    assign cmd = mem_cmd_e'(mem_cmd);
    // Full-width compare so high address bits never alias into RAM.
    assign is_ram = 32'(mem_addr) < RAM_DEPTH;
    assign is_led = mem_addr == LED_ADDR;
    assign is_sw  = mem_addr == SW_ADDR;

`ifdef MEM_BUS_ERR_EN
    assign accept = (state_q == StIdle) && (cmd != MNONE);
`else
    assign accept = (state_q == StIdle) && ((cmd == MREAD) || (cmd == MWRITE));
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        mem_ready_d = 1'b0;
        ram_write_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        led_d       = led_q;
        err_hit     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StResp;
                    mem_ready_d = 1'b1;
                    if (cmd == MREAD) begin
                        if (is_ram) begin
                            ram_addr_d  = mem_addr[RAM_AW-1:0];
                            cnt_d       = 3'(RAM_LAT - 1);
                            state_d     = StRamWait;
                            mem_ready_d = 1'b0;
                        end else if (is_led) begin
                            read_data_d = DATA_W'(led_q);
                        end else if (is_sw) begin
                            read_data_d = DATA_W'(sw_sync);
                        end else begin
                            read_data_d = '0;
                            err_hit     = 1'b1;
                        end
                    end else if (cmd == MWRITE) begin
                        if (is_ram) begin
                            ram_addr_d  = mem_addr[RAM_AW-1:0];
                            ram_din_d   = write_data;
                            ram_write_d = 1'b1;
                        end else if (is_led) begin
                            led_d = write_data[IO_W-1:0];
                        end else begin
                            // Switch writes and unmapped writes are dropped.
                            err_hit = 1'b1;
                        end
                    end else begin
                        // Reserved command: completes with no side effects.
                        err_hit = 1'b1;
                    end
                end
            end
            StRamWait: begin
                if (cnt_q == 3'd0) begin
                    read_data_d = ram_dout;
                    mem_ready_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            led_q       <= led_d;
        end
    end

`ifdef MEM_BUS_ERR_EN
    logic bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if (err_hit) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_err;
    assign unused_err = err_hit;
`endif

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_write = ram_write_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: one instance with RAM_LAT=1, one with RAM_LAT=3, each
// with its own RAM model. Expected read data is queued when a request is driven
// and popped when mem_ready is seen.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_init;
    logic [1:0]  cmd   [2];
    logic [8:0]  addr  [2];
    logic [15:0] wdata [2];
    logic [7:0]  sw    [2];
    logic [15:0] rdata [2];
    logic        ready [2];
    logic [7:0]  raddr [2];
    logic [15:0] rdin  [2];
    logic        rwr   [2];
    logic [15:0] rdout [2];
    logic [7:0]  led   [2];
`ifdef MEM_BUS_ERR_EN
    logic        berr  [2];
`endif

    mem_bus_ctrl #(
        .RAM_LAT(1)
    ) u_lat1 (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (cmd[0]),
        .mem_addr  (addr[0]),
        .write_data(wdata[0]),
        .read_data (rdata[0]),
        .mem_ready (ready[0]),
        .ram_addr  (raddr[0]),
        .ram_din   (rdin[0]),
        .ram_write (rwr[0]),
        .ram_dout  (rdout[0]),
        .sw_in     (sw[0]),
        .led_out   (led[0])
`ifdef MEM_BUS_ERR_EN
        ,
        .bus_err   (berr[0])
`endif
    );

    mem_bus_ctrl #(
        .RAM_LAT(3)
    ) u_lat3 (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (cmd[1]),
        .mem_addr  (addr[1]),
        .write_data(wdata[1]),
        .read_data (rdata[1]),
        .mem_ready (ready[1]),
        .ram_addr  (raddr[1]),
        .ram_din   (rdin[1]),
        .ram_write (rwr[1]),
        .ram_dout  (rdout[1]),
        .sw_in     (sw[1]),
        .led_out   (led[1])
`ifdef MEM_BUS_ERR_EN
        ,
        .bus_err   (berr[1])
`endif
    );

    function automatic logic [15:0] init1(input int i);
        return 16'(16'h1000 + i * 7);
    endfunction

    // RAM models: latency 1 reads through combinationally; latency 3 uses two
    // output pipeline stages so early sampling returns stale data.
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] pipe1_a, pipe1_b;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= '0;
                mem1[i] <= init1(i);
            end
        end else begin
            if (rwr[0]) mem0[raddr[0]] <= rdin[0];
            if (rwr[1]) mem1[raddr[1]] <= rdin[1];
        end
        pipe1_a <= mem1[raddr[1]];
        pipe1_b <= pipe1_a;
    end

    assign rdout[0] = mem0[raddr[0]];
    assign rdout[1] = pipe1_b;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q [$];
    logic [15:0] last_rd [2];
    logic [7:0]  led_snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request (called #1 after a rising edge) and follow it to mem_ready.
    task automatic txn(input int u, input logic [1:0] c, input logic [8:0] a,
                       input logic [15:0] d, input bit ram_wr, input int exp_lat,
                       input logic [15:0] exp_rd, input string tag);
        int          lat  = 0;
        bit          seen = 1'b0;
        logic [15:0] e;
        cmd[u]   = c;
        addr[u]  = a;
        wdata[u] = d;
        exp_q.push_back(exp_rd);
        @(posedge clk);
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            check({tag, "/ram_write"}, 32'(rwr[u]), 32'(ready[u] && ram_wr));
            if (ready[u]) begin
                seen     = 1'b1;
                led_snap = led[u];
            end
        end
        cmd[u] = MNONE;
        check({tag, "/ready_seen"}, 32'(seen), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        e = exp_q.pop_front();
        check({tag, "/read_data"}, 32'(rdata[u]), 32'(e));
        last_rd[u] = exp_rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        for (int u = 0; u < 2; u++) begin
            cmd[u]     = MNONE;
            addr[u]    = '0;
            wdata[u]   = '0;
            sw[u]      = '0;
            last_rd[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_init = 1'b0;

        repeat (5) begin
            @(negedge clk);
            check("idle/ready0", 32'(ready[0]), 32'd0);
            check("idle/ready1", 32'(ready[1]), 32'd0);
        end
        check("reset/read_data", 32'(rdata[0]), 32'd0);
        check("reset/ram_addr", 32'(raddr[0]), 32'd0);
        check("reset/ram_din", 32'(rdin[0]), 32'd0);
        check("reset/ram_write", 32'(rwr[0]), 32'd0);
        check("reset/led_out", 32'(led[0]), 32'd0);
        @(posedge clk);
        #1;

        // RAM, latency 1
        txn(0, MWRITE, 9'h003, 16'h0005, 1'b1, 1, last_rd[0], "ram_wr3");
        check("ram_wr3/ram_addr", 32'(raddr[0]), 32'h3);
        check("ram_wr3/ram_din", 32'(rdin[0]), 32'h5);
        txn(0, MREAD, 9'h003, 16'h0000, 1'b0, 2, 16'h0005, "ram_rd3");
        txn(0, MWRITE, 9'h0FF, 16'h1234, 1'b1, 1, last_rd[0], "ram_wr_top");
        txn(0, MREAD, 9'h0FF, 16'h0000, 1'b0, 2, 16'h1234, "ram_rd_top");

        // RAM, latency 3
        txn(1, MREAD, 9'h010, 16'h0000, 1'b0, 4, init1(16), "lat3_rd10");
        txn(1, MWRITE, 9'h020, 16'hC0DE, 1'b1, 1, last_rd[1], "lat3_wr20");
        txn(1, MREAD, 9'h020, 16'h0000, 1'b0, 4, 16'hC0DE, "lat3_rd20");

        // LED register
        txn(0, MWRITE, 9'h100, 16'h5AA5, 1'b0, 1, last_rd[0], "led_wr");
        check("led_wr/led_at_ready", 32'(led_snap), 32'hA5);
        txn(0, MREAD, 9'h100, 16'h0000, 1'b0, 1, 16'h00A5, "led_rd");

        // Switch register through the synchroniser
        sw[0] = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        txn(0, MREAD, 9'h140, 16'h0000, 1'b0, 1, 16'h003C, "sw_rd");
        sw[0] = 8'hC3;
        txn(0, MREAD, 9'h140, 16'h0000, 1'b0, 1, 16'h003C, "sw_old");
        repeat (3) @(posedge clk);
        #1;
        txn(0, MREAD, 9'h140, 16'h0000, 1'b0, 1, 16'h00C3, "sw_new");

`ifdef MEM_BUS_ERR_EN
        check("bus_err/clear", 32'(berr[0]), 32'd0);
`endif
        // Unmapped and aliasing addresses
        txn(0, MREAD, 9'h1FF, 16'h0000, 1'b0, 1, 16'h0000, "unmap_rd");
`ifdef MEM_BUS_ERR_EN
        check("bus_err/set", 32'(berr[0]), 32'd1);
`endif
        txn(0, MWRITE, 9'h103, 16'h7777, 1'b0, 1, last_rd[0], "alias_wr");
        txn(0, MREAD, 9'h003, 16'h0000, 1'b0, 2, 16'h0005, "alias_chk");
        txn(0, MWRITE, 9'h140, 16'hFFFF, 1'b0, 1, last_rd[0], "sw_wr");
        txn(0, MREAD, 9'h140, 16'h0000, 1'b0, 1, 16'h00C3, "sw_after_wr");
`ifdef MEM_BUS_ERR_EN
        check("bus_err/sticky", 32'(berr[0]), 32'd1);
`endif

        // Reserved command
`ifdef MEM_BUS_ERR_EN
        check("rsvd/bus_err_before", 32'(berr[1]), 32'd0);
        txn(1, MRSVD, 9'h003, 16'h0000, 1'b0, 1, last_rd[1], "rsvd");
        check("rsvd/bus_err_after", 32'(berr[1]), 32'd1);
`else
        cmd[1] = MRSVD;
        repeat (4) begin
            @(negedge clk);
            check("rsvd/no_ready", 32'(ready[1]), 32'd0);
            check("rsvd/no_ram_write", 32'(rwr[1]), 32'd0);
        end
        cmd[1] = MNONE;
        @(posedge clk);
        #1;
`endif

        // Reset while the latency-3 instance sits in RAM_WAIT
        cmd[1]  = MREAD;
        addr[1] = 9'h030;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cmd[1] = MNONE;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid/no_ready", 32'(ready[1]), 32'd0);
            check("rst_mid/no_ram_write", 32'(rwr[1]), 32'd0);
        end
        check("rst_mid/led_cleared", 32'(led[0]), 32'd0);
        check("rst_mid/read_data0", 32'(rdata[1]), 32'd0);
`ifdef MEM_BUS_ERR_EN
        check("rst_mid/bus_err_cleared", 32'(berr[0]), 32'd0);
`endif
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk);
        #1;
        txn(1, MREAD, 9'h030, 16'h0000, 1'b0, 4, init1(48), "post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
